// File: rtl/rst_seq_pkg.sv
// Shared types and helpers for the staged reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    ACK     = 2'd3
  } rst_seq_state_t;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// Software request handshake and staged reset outputs of one clock domain.
interface reset_sequencer_if #(
  parameter int unsigned NUM_STAGES = 4
) ();

  logic                  sw_rst_req;
  logic                  sw_rst_ack;
  logic [NUM_STAGES-1:0] stage_rst_out;
  logic                  all_released;
  logic                  busy;

  modport master (
    output sw_rst_req,
    input  sw_rst_ack,
    input  stage_rst_out,
    input  all_released,
    input  busy
  );

  modport slave (
    input  sw_rst_req,
    output sw_rst_ack,
    output stage_rst_out,
    output all_released,
    output busy
  );

endinterface

// File: rtl/rst_seq_timer.sv
// Interval timer: counts while enabled, cleared synchronously, flags terminal count.
module rst_seq_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] tc_val,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tc = en && (cnt == tc_val);

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator: holds every stage, releases them in index order,
// and restarts on rst or on a 4-phase software request.
module reset_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES  = 4,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGE_GAP   = 8
) (
  input  logic              clk,
  input  logic              rst,
  reset_sequencer_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, STAGE_GAP) + 1);
  localparam int unsigned IDX_W = $clog2(NUM_STAGES + 1);

  if (NUM_STAGES < 1 || HOLD_CYCLES < 1 || STAGE_GAP < 1) begin : g_param_check
    $error("reset_sequencer: NUM_STAGES, HOLD_CYCLES and STAGE_GAP must all be >= 1");
  end

  rst_seq_state_t        state, state_d;
  logic [IDX_W-1:0]      stage_idx, stage_idx_d;
  logic [NUM_STAGES-1:0] stage_rst, stage_d;
  logic                  pending, pending_d;
  logic                  ack, ack_d;
  logic                  all_rel;
  logic                  busy_r;
  logic                  done_c;
  logic                  timer_en_c;
  logic                  timer_clr_c;
  logic [CNT_W-1:0]      tc_val_c;
  logic                  tc_c;

  // Timer runs only while stages are being held or released; restarts on every state change.
  assign timer_en_c  = (state == HOLD) || (state == RELEASE);
  assign tc_val_c    = (state == HOLD) ? CNT_W'(HOLD_CYCLES - 1) : CNT_W'(STAGE_GAP - 1);
  assign timer_clr_c = tc_c || (state_d != state);

  rst_seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr_c),
    .en     (timer_en_c),
    .tc_val (tc_val_c),
    .tc     (tc_c)
  );

  always_comb begin
    state_d     = state;
    stage_idx_d = stage_idx;
    stage_d     = stage_rst;
    pending_d   = pending;
    ack_d       = ack;
    done_c      = 1'b0;

    unique case (state)
      HOLD: begin
        if (tc_c) begin
          stage_d[0]  = 1'b0;
          stage_idx_d = IDX_W'(1);
          if (NUM_STAGES == 1) begin
            done_c = 1'b1;
          end else begin
            state_d = RELEASE;
          end
        end
      end
      RELEASE: begin
        if (tc_c) begin
          for (int i = 0; i < NUM_STAGES; i++) begin
            if (IDX_W'(i) == stage_idx) begin
              stage_d[i] = 1'b0;
            end
          end
          stage_idx_d = stage_idx + IDX_W'(1);
          done_c      = (stage_idx == IDX_W'(NUM_STAGES - 1));
        end
      end
      RUN: begin
        if (bus.sw_rst_req && !ack) begin
          stage_d     = '1;
          stage_idx_d = '0;
          pending_d   = 1'b1;
          state_d     = HOLD;
        end
      end
      ACK: begin
        if (!bus.sw_rst_req) begin
          ack_d   = 1'b0;
          state_d = RUN;
        end
      end
      default: begin
        state_d = HOLD;
      end
    endcase

    // Last stage released: a software-started sequence finishes through ACK.
    if (done_c) begin
      state_d   = pending ? ACK : RUN;
      ack_d     = pending;
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HOLD;
      stage_idx <= '0;
      stage_rst <= '1;
      pending   <= 1'b0;
      ack       <= 1'b0;
      all_rel   <= 1'b0;
      busy_r    <= 1'b1;
    end else begin
      state     <= state_d;
      stage_idx <= stage_idx_d;
      stage_rst <= stage_d;
      pending   <= pending_d;
      ack       <= ack_d;
      all_rel   <= ~|stage_d;
      busy_r    <= |stage_d;
    end
  end

  assign bus.stage_rst_out = stage_rst;
  assign bus.all_released  = all_rel;
  assign bus.busy          = busy_r;
  assign bus.sw_rst_ack    = ack;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench for reset_sequencer: two configurations checked against a
// schedule-based reference model (stage i is held while t < HOLD + i*GAP).
module tb_reset_sequencer;

  localparam int A_NS = 4, A_HOLD = 16, A_GAP = 8;
  localparam int B_NS = 1, B_HOLD = 1,  B_GAP = 1;

  logic clk;
  logic rst;
  logic req;

  reset_sequencer_if #(.NUM_STAGES(A_NS)) bus_a ();
  reset_sequencer_if #(.NUM_STAGES(B_NS)) bus_b ();

  assign bus_a.sw_rst_req = req;
  assign bus_b.sw_rst_req = req;

  reset_sequencer #(
    .NUM_STAGES(A_NS), .HOLD_CYCLES(A_HOLD), .STAGE_GAP(A_GAP)
  ) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  reset_sequencer #(
    .NUM_STAGES(B_NS), .HOLD_CYCLES(B_HOLD), .STAGE_GAP(B_GAP)
  ) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: t = edges since the sequence started (rst edge or sw start edge).
  typedef struct packed {
    int t;
    bit seq;
    bit sw;
    bit ack;
  } mdl_t;

  function automatic mdl_t mdl_step(mdl_t m, bit r, bit q, int ns, int hold, int gap);
    mdl_t n = m;
    if (r) begin
      n.t = 0; n.seq = 1'b1; n.sw = 1'b0; n.ack = 1'b0;
    end else if (m.seq) begin
      n.t = m.t + 1;
      if (n.t >= hold + (ns - 1) * gap) begin
        n.seq = 1'b0;
        n.ack = m.sw;
        n.sw  = 1'b0;
      end
    end else if (m.ack) begin
      if (!q) n.ack = 1'b0;
    end else if (q) begin
      n.t = 0; n.seq = 1'b1; n.sw = 1'b1;
    end
    return n;
  endfunction

  function automatic logic [3:0] mdl_stages(mdl_t m, int ns, int hold, int gap);
    logic [3:0] v = '0;
    for (int i = 0; i < ns; i++) v[i] = m.seq && (m.t < hold + i * gap);
    return v;
  endfunction

  mdl_t ma = '{t: 0, seq: 1'b1, sw: 1'b0, ack: 1'b0};
  mdl_t mb = '{t: 0, seq: 1'b1, sw: 1'b0, ack: 1'b0};
  bit   armed = 1'b0;

  always @(posedge clk) begin
    ma    <= mdl_step(ma, rst, req, A_NS, A_HOLD, A_GAP);
    mb    <= mdl_step(mb, rst, req, B_NS, B_HOLD, B_GAP);
    armed <= armed | rst;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_dut(input string nm, input logic [3:0] st, input logic ar,
                           input logic bz, input logic ak, input mdl_t m,
                           input int ns, input int hold, input int gap,
                           input logic [3:0] prev);
    logic [3:0] mask;
    logic [3:0] inv;
    logic [3:0] rise;
    mask = 4'((1 << ns) - 1);
    inv  = ~st & mask;
    rise = ~prev & st;
    check_eq({nm, "_stage"},   32'(st), 32'(mdl_stages(m, ns, hold, gap)));
    check_eq({nm, "_all_rel"}, 32'(ar), 32'(!m.seq));
    check_eq({nm, "_busy"},    32'(bz), 32'(m.seq));
    check_eq({nm, "_ack"},     32'(ak), 32'(m.ack));
    check_eq({nm, "_busy_inv"}, 32'(bz ^ ar), 32'd1);
    check_eq({nm, "_order"},   32'((inv & (inv + 4'd1)) == 4'd0), 32'd1);
    check_eq({nm, "_rise"},    32'((rise == 4'd0) || (st == mask)), 32'd1);
  endtask

  logic [3:0] prev_a = 4'hF;
  logic [3:0] prev_b = 4'hF;

  task automatic check_all();
    if (armed) begin
      check_dut("a", 4'(bus_a.stage_rst_out), bus_a.all_released, bus_a.busy,
                bus_a.sw_rst_ack, ma, A_NS, A_HOLD, A_GAP, prev_a);
      check_dut("b", 4'(bus_b.stage_rst_out), bus_b.all_released, bus_b.busy,
                bus_b.sw_rst_ack, mb, B_NS, B_HOLD, B_GAP, prev_b);
      prev_a = 4'(bus_a.stage_rst_out);
      prev_b = 4'(bus_b.stage_rst_out);
    end
  endtask

  task automatic cyc(input bit r, input bit q, input int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
      rst = r;
      req = q;
    end
  endtask

  initial begin
    bit q;
    rst = 1'b1;
    req = 1'b0;
    // Power-on sequence.
    cyc(1'b1, 1'b0, 3);
    cyc(1'b0, 1'b0, 45);
    // Request held through ACK and well beyond: only one sequence.
    cyc(1'b0, 1'b1, 60);
    cyc(1'b0, 1'b0, 5);
    // Fresh request after the drop: exactly one new sequence, then release.
    cyc(1'b0, 1'b1, 45);
    cyc(1'b0, 1'b0, 5);
    // rst pulse on edge 28 of a power-on sequence.
    cyc(1'b1, 1'b0, 1);
    cyc(1'b0, 1'b0, 27);
    cyc(1'b1, 1'b0, 1);
    cyc(1'b0, 1'b0, 50);
    // rst during an ACK wait clears the stale ack.
    cyc(1'b0, 1'b1, 45);
    cyc(1'b1, 1'b1, 1);
    cyc(1'b0, 1'b0, 45);
    // Randomized requests with occasional resets.
    q = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) q = ~q;
      cyc(($urandom_range(0, 399) == 0), q, 1);
    end
    cyc(1'b0, 1'b0, 50);
    @(negedge clk);
    check_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
